// File: rtl/sprite_motion.sv
// Per-frame sprite position/velocity update with edge reflection.
// A synchronised frame_int rising edge starts a CALC -> CHECK -> COMMIT pass; both offsets load together in COMMIT.
module sprite_motion #(
    parameter int SCREEN_W = 800,
    parameter int SCREEN_H = 480,
    parameter int SPRITE_W = 64,
    parameter int SPRITE_H = 64,
    parameter int INIT_X   = 123,
    parameter int INIT_Y   = 234,
    parameter int INIT_VX  = 1,
    parameter int INIT_VY  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_int,
    input  logic        pause,
    input  logic        vel_we,
    input  logic [7:0]  vel_x_in,
    input  logic [7:0]  vel_y_in,
    output logic [15:0] offset_x,
    output logic [15:0] offset_y,
    output logic [7:0]  vel_x,
    output logic [7:0]  vel_y,
    output logic        hit_x,
    output logic        hit_y,
    output logic [15:0] bounce_count,
    output logic        busy,
    output logic [1:0]  state_dbg
);
    localparam logic signed [17:0] MAX_X = 18'(SCREEN_W - SPRITE_W);
    localparam logic signed [17:0] MAX_Y = 18'(SCREEN_H - SPRITE_H);

    typedef enum logic [1:0] {IDLE, CALC, CHECK, COMMIT} state_t;
    state_t state_q, state_d;

    logic        s1_q, s2_q, s3_q, armed_q;
    logic [1:0]  arm_cnt_q;
    logic        fire;
    logic [15:0] off_x_q, off_x_d, off_y_q, off_y_d;
    logic [7:0]  vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    logic signed [16:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [15:0] wpos_x_q, wpos_x_d, wpos_y_q, wpos_y_d;
    logic [7:0]  wvel_x_q, wvel_x_d, wvel_y_q, wvel_y_d;
    logic        whit_x_q, whit_x_d, whit_y_q, whit_y_d;
    logic        pend_q, pend_d;
    logic [7:0]  pvx_q, pvx_d, pvy_q, pvy_d;
    logic        hit_x_q, hit_x_d, hit_y_q, hit_y_d;
    logic [15:0] bc_q, bc_d;
    logic [16:0] bc_sum;
    logic [24:0] rx, ry;

    // |v| with -128 saturating to +127 so the negation stays representable.
    function automatic logic [7:0] vel_mag(input logic [7:0] v);
        if (v == 8'h80)
            return 8'h7f;
        else if (v[7])
            return ~v + 8'd1;
        else
            return v;
    endfunction

    // Returns {hit, new_vel, new_pos}.
    function automatic logic [24:0] reflect(input logic signed [16:0] sum, input logic [7:0] v,
                                            input logic signed [17:0] maxv);
        logic signed [17:0] s, p;
        logic [7:0] m, nv;
        logic h;
        s  = {sum[16], sum};
        m  = vel_mag(v);
        nv = v;
        h  = 1'b0;
        if (s < 18'sd0) begin
            p = -s; nv = m; h = 1'b1;
        end else if (s > maxv) begin
            p = (maxv <<< 1) - s; nv = ~m + 8'd1; h = 1'b1;
        end else begin
            p = s;
        end
        if (p < 18'sd0)
            p = 18'sd0;
        else if (p > maxv)
            p = maxv;
        return {h, nv, p[15:0]};
    endfunction

    // Arming blocks a spurious edge when frame_int is already high as reset releases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0; s2_q <= 1'b0; s3_q <= 1'b0;
            arm_cnt_q <= 2'd0; armed_q <= 1'b0;
        end else begin
            s1_q <= frame_int; s2_q <= s1_q; s3_q <= s2_q;
            if (arm_cnt_q != 2'd2) arm_cnt_q <= arm_cnt_q + 2'd1;
            if (arm_cnt_q == 2'd2 && !s2_q) armed_q <= 1'b1;
        end
    end

    assign fire = s2_q & ~s3_q & armed_q;

    always_comb begin
        state_d = state_q;
        off_x_d = off_x_q;   off_y_d = off_y_q;
        vel_x_d = vel_x_q;   vel_y_d = vel_y_q;
        sum_x_d = sum_x_q;   sum_y_d = sum_y_q;
        wpos_x_d = wpos_x_q; wpos_y_d = wpos_y_q;
        wvel_x_d = wvel_x_q; wvel_y_d = wvel_y_q;
        whit_x_d = whit_x_q; whit_y_d = whit_y_q;
        pend_d = pend_q;     pvx_d = pvx_q;   pvy_d = pvy_q;
        hit_x_d = 1'b0;      hit_y_d = 1'b0;
        bc_d = bc_q;
        bc_sum = {1'b0, bc_q} + 17'(whit_x_q) + 17'(whit_y_q);
        rx = reflect(sum_x_q, vel_x_q, MAX_X);
        ry = reflect(sum_y_q, vel_y_q, MAX_Y);

        if (vel_we) begin
            if (state_q == IDLE) begin
                vel_x_d = vel_x_in; vel_y_d = vel_y_in;
            end else begin
                pend_d = 1'b1; pvx_d = vel_x_in; pvy_d = vel_y_in;
            end
        end

        case (state_q)
            IDLE: if (fire && !pause) state_d = CALC;
            CALC: begin
                sum_x_d = $signed({off_x_q[15], off_x_q}) + $signed({{9{vel_x_q[7]}}, vel_x_q});
                sum_y_d = $signed({off_y_q[15], off_y_q}) + $signed({{9{vel_y_q[7]}}, vel_y_q});
                state_d = CHECK;
            end
            CHECK: begin
                wpos_x_d = rx[15:0]; wvel_x_d = rx[23:16]; whit_x_d = rx[24];
                wpos_y_d = ry[15:0]; wvel_y_d = ry[23:16]; whit_y_d = ry[24];
                state_d  = COMMIT;
            end
            COMMIT: begin
                off_x_d = wpos_x_q; off_y_d = wpos_y_q;
                hit_x_d = whit_x_q; hit_y_d = whit_y_q;
                bc_d    = bc_sum[16] ? 16'hffff : bc_sum[15:0];
                // A strobe landing on COMMIT itself is newest and wins.
                if (vel_we) begin
                    vel_x_d = vel_x_in; vel_y_d = vel_y_in;
                end else if (pend_q) begin
                    vel_x_d = pvx_q; vel_y_d = pvy_q;
                end else begin
                    vel_x_d = wvel_x_q; vel_y_d = wvel_y_q;
                end
                pend_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            off_x_q <= 16'(INIT_X);  off_y_q <= 16'(INIT_Y);
            vel_x_q <= 8'(INIT_VX);  vel_y_q <= 8'(INIT_VY);
            sum_x_q <= '0;           sum_y_q <= '0;
            wpos_x_q <= '0;          wpos_y_q <= '0;
            wvel_x_q <= '0;          wvel_y_q <= '0;
            whit_x_q <= 1'b0;        whit_y_q <= 1'b0;
            pend_q <= 1'b0;          pvx_q <= '0;     pvy_q <= '0;
            hit_x_q <= 1'b0;         hit_y_q <= 1'b0;
            bc_q <= '0;
        end else begin
            state_q <= state_d;
            off_x_q <= off_x_d;      off_y_q <= off_y_d;
            vel_x_q <= vel_x_d;      vel_y_q <= vel_y_d;
            sum_x_q <= sum_x_d;      sum_y_q <= sum_y_d;
            wpos_x_q <= wpos_x_d;    wpos_y_q <= wpos_y_d;
            wvel_x_q <= wvel_x_d;    wvel_y_q <= wvel_y_d;
            whit_x_q <= whit_x_d;    whit_y_q <= whit_y_d;
            pend_q <= pend_d;        pvx_q <= pvx_d;  pvy_q <= pvy_d;
            hit_x_q <= hit_x_d;      hit_y_q <= hit_y_d;
            bc_q <= bc_d;
        end
    end

    assign offset_x     = off_x_q;
    assign offset_y     = off_y_q;
    assign vel_x        = vel_x_q;
    assign vel_y        = vel_y_q;
    assign hit_x        = hit_x_q;
    assign hit_y        = hit_y_q;
    assign bounce_count = bc_q;
    assign busy         = (state_q != IDLE);
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_sprite_motion.sv
// Bench for sprite_motion: a table of per-frame velocity loads with expected results,
// plus hand sequences for reset-with-frame-high, velocity write while busy and reset mid-update.
module tb_sprite_motion;
    logic        clk = 1'b0;
    logic        reset, frame_int, pause, vel_we;
    logic [7:0]  vel_x_in, vel_y_in;
    logic [15:0] offset_x, offset_y, bounce_count;
    logic [7:0]  vel_x, vel_y;
    logic        hit_x, hit_y, busy;
    logic [1:0]  state_dbg;

    sprite_motion dut (
        .clk(clk), .reset(reset), .frame_int(frame_int), .pause(pause), .vel_we(vel_we),
        .vel_x_in(vel_x_in), .vel_y_in(vel_y_in), .offset_x(offset_x), .offset_y(offset_y),
        .vel_x(vel_x), .vel_y(vel_y), .hit_x(hit_x), .hit_y(hit_y),
        .bounce_count(bounce_count), .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    localparam int EW = 66;
    typedef struct {
        logic [7:0]  vx, vy;
        logic        pz;
        logic [15:0] ex, ey;
        logic [7:0]  evx, evy;
        logic        ehx, ehy;
        logic [15:0] ebc;
    } vec_t;

    vec_t tbl[18];
    logic [EW-1:0] exp_q[$];
    int checks = 0, errors = 0, commits = 0;
    int busy_cnt = 0;
    logic busy_prev = 1'b0, hit_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] vx, input logic [7:0] vy, input logic pz,
                                input logic [15:0] ex, input logic [15:0] ey, input logic [7:0] evx,
                                input logic [7:0] evy, input logic ehx, input logic ehy,
                                input logic [15:0] ebc);
        vec_t v;
        v.vx = vx; v.vy = vy; v.pz = pz; v.ex = ex; v.ey = ey;
        v.evx = evx; v.evy = evy; v.ehx = ehx; v.ehy = ehy; v.ebc = ebc;
        return v;
    endfunction

    function automatic logic [EW-1:0] pack_exp(input vec_t v);
        return {v.ex, v.ey, v.evx, v.evy, v.ehx, v.ehy, v.ebc};
    endfunction

    // Scoreboard: each completed update (busy falling) is compared against the oldest expectation.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!reset) begin
            busy_prev = 1'b0; busy_cnt = 0; hit_chk = 1'b0;
            exp_q.delete();
        end else begin
            if (hit_chk) begin
                check("hit_pulse_len", {30'd0, hit_x, hit_y}, 32'd0);
                hit_chk = 1'b0;
            end
            if (busy) busy_cnt++;
            if (busy_prev && !busy) begin
                commits++;
                check("busy_cycles", busy_cnt, 3);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_update: got x=%0d y=%0d expected no update", offset_x, offset_y);
                end else begin
                    e = exp_q.pop_front();
                    check("offset_x", offset_x, e[65:50]);
                    check("offset_y", offset_y, e[49:34]);
                    check("vel_x", vel_x, e[33:26]);
                    check("vel_y", vel_y, e[25:18]);
                    check("hit_x", hit_x, e[17]);
                    check("hit_y", hit_y, e[16]);
                    check("bounce_count", bounce_count, e[15:0]);
                end
                hit_chk = 1'b1;
                busy_cnt = 0;
            end
            busy_prev = busy;
        end
    end

    task automatic load_vel(input logic [7:0] vx, input logic [7:0] vy);
        @(posedge clk); #1;
        vel_we = 1'b1; vel_x_in = vx; vel_y_in = vy;
        @(posedge clk); #1;
        vel_we = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        checks++;
        if (exp_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL timeout: got %0d pending updates expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic do_frame(input logic p);
        @(posedge clk); #1;
        frame_int = 1'b1; pause = p;
        repeat (3) @(posedge clk);
        #1 frame_int = 1'b0;
        wait_idle();
        pause = 1'b0;
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy) break;
        end
        checks++;
        if (!busy) begin
            errors++;
            $display("FAIL busy_rise: got busy=0 expected 1");
        end
    endtask

    initial begin
        int c0;
        tbl[0]  = mk(8'h01, 8'h01, 0, 124, 235, 8'h01, 8'h01, 0, 0, 0);
        tbl[1]  = mk(8'h7f, 8'h00, 0, 251, 235, 8'h7f, 8'h00, 0, 0, 0);
        tbl[2]  = mk(8'h7f, 8'h00, 0, 378, 235, 8'h7f, 8'h00, 0, 0, 0);
        tbl[3]  = mk(8'h7f, 8'h00, 0, 505, 235, 8'h7f, 8'h00, 0, 0, 0);
        tbl[4]  = mk(8'h7f, 8'h00, 0, 632, 235, 8'h7f, 8'h00, 0, 0, 0);
        tbl[5]  = mk(8'h62, 8'h00, 0, 730, 235, 8'h62, 8'h00, 0, 0, 0);
        tbl[6]  = mk(8'h0a, 8'h00, 0, 732, 235, 8'hf6, 8'h00, 1, 0, 1);
        tbl[7]  = mk(8'h80, 8'h5a, 0, 604, 325, 8'h80, 8'h5a, 0, 0, 1);
        tbl[8]  = mk(8'h80, 8'h59, 0, 476, 414, 8'h80, 8'h59, 0, 0, 1);
        tbl[9]  = mk(8'h80, 8'h00, 0, 348, 414, 8'h80, 8'h00, 0, 0, 1);
        tbl[10] = mk(8'h80, 8'h00, 0, 220, 414, 8'h80, 8'h00, 0, 0, 1);
        tbl[11] = mk(8'h80, 8'h00, 0, 92,  414, 8'h80, 8'h00, 0, 0, 1);
        tbl[12] = mk(8'ha6, 8'h00, 0, 2,   414, 8'ha6, 8'h00, 0, 0, 1);
        tbl[13] = mk(8'hfb, 8'h04, 0, 3,   414, 8'h05, 8'hfc, 1, 1, 3);
        tbl[14] = mk(8'h80, 8'h00, 0, 125, 414, 8'h7f, 8'h00, 1, 0, 4);
        tbl[15] = mk(8'h00, 8'h02, 0, 125, 416, 8'h00, 8'h02, 0, 0, 4);
        tbl[16] = mk(8'h00, 8'h00, 1, 125, 416, 8'h00, 8'h00, 0, 0, 4);
        tbl[17] = mk(8'h00, 8'h05, 0, 125, 411, 8'h00, 8'hfb, 0, 1, 5);

        reset = 1'b0; frame_int = 1'b1; pause = 1'b0; vel_we = 1'b0;
        vel_x_in = 8'h00; vel_y_in = 8'h00;
        #22;
        check("rst_offset_x", offset_x, 123);
        check("rst_offset_y", offset_y, 234);
        check("rst_vel_x", vel_x, 1);
        check("rst_vel_y", vel_y, 1);
        check("rst_bounce", bounce_count, 0);
        check("rst_busy", busy, 0);
        check("rst_hits", {hit_x, hit_y}, 0);

        // frame_int already high at release: no update until a fresh rising edge.
        @(posedge clk); #1 reset = 1'b1;
        c0 = commits;
        repeat (10) @(posedge clk);
        #1;
        check("held_high_commits", commits, c0);
        check("held_high_offset_x", offset_x, 123);
        frame_int = 1'b0;
        repeat (8) @(posedge clk);

        for (int i = 0; i < 18; i++) begin
            load_vel(tbl[i].vx, tbl[i].vy);
            c0 = commits;
            if (!tbl[i].pz) exp_q.push_back(pack_exp(tbl[i]));
            do_frame(tbl[i].pz);
            check($sformatf("row%0d_commits", i), commits - c0, tbl[i].pz ? 0 : 1);
            if (tbl[i].pz) begin
                check("pause_offset_x", offset_x, tbl[i].ex);
                check("pause_offset_y", offset_y, tbl[i].ey);
                check("pause_bounce", bounce_count, tbl[i].ebc);
            end
        end

        // Velocity write while busy: this frame moves by (0,-5), then velocity becomes (3,-2).
        exp_q.push_back(pack_exp(mk(8'h00, 8'h00, 0, 125, 406, 8'h03, 8'hfe, 0, 0, 5)));
        @(posedge clk); #1 frame_int = 1'b1;
        wait_busy();
        vel_we = 1'b1; vel_x_in = 8'h03; vel_y_in = 8'hfe;
        @(posedge clk); #1 vel_we = 1'b0;
        frame_int = 1'b0;
        wait_idle();
        exp_q.push_back(pack_exp(mk(8'h00, 8'h00, 0, 128, 404, 8'h03, 8'hfe, 0, 0, 5)));
        do_frame(1'b0);

        // Reset in CHECK: everything returns to reset values immediately.
        exp_q.push_back(pack_exp(mk(8'h00, 8'h00, 0, 125, 402, 8'h03, 8'hfe, 0, 0, 5)));
        @(posedge clk); #1 frame_int = 1'b1;
        wait_busy();
        @(posedge clk); #1;
        check("state_check", state_dbg, 2);
        #2 reset = 1'b0;
        #1;
        check("midrst_offset_x", offset_x, 123);
        check("midrst_offset_y", offset_y, 234);
        check("midrst_vel_x", vel_x, 1);
        check("midrst_bounce", bounce_count, 0);
        check("midrst_busy", busy, 0);
        frame_int = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (8) @(posedge clk);
        exp_q.push_back(pack_exp(mk(8'h00, 8'h00, 0, 124, 235, 8'h01, 8'h01, 0, 0, 0)));
        do_frame(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_motion.md
# sprite_motion

Per-frame motion controller for the bouncing sprite. It runs in the 144 MHz system clock domain and sits directly upstream of the LCD/VGA sprite renderer, driving that renderer's `offset_x_in`/`offset_y_in`. On every frame interrupt it advances the sprite position by a signed velocity and reflects off the screen edges with exact overshoot mirroring. Both offsets update atomically in a single cycle, so the renderer never sees a torn X/Y pair.

## Interface
- SCREEN_W, 800: visible width in pixels.
- SCREEN_H, 480: visible height in pixels.
- SPRITE_W, 64: sprite width.
- SPRITE_H, 64: sprite height.
- INIT_X, 123: reset X position.
- INIT_Y, 234: reset Y position.
- INIT_VX, 1: reset X velocity.
- INIT_VY, 1: reset Y velocity.

- clk  in  1  system clock (144 MHz).
- reset  in  1  reset, asynchronous, active-low.
- frame_int  in  1  frame pulse/level from the pixel-clock domain; asynchronous to clk.
- pause  in  1  when high at frame detection, the frame is skipped.
- vel_we  in  1  one-cycle strobe that loads vel_x_in/vel_y_in.
- vel_x_in  in  8  signed X velocity in px/frame.
- vel_y_in  in  8  signed Y velocity in px/frame.
- offset_x  out  16  signed sprite X to the renderer.
- offset_y  out  16  signed sprite Y to the renderer.
- vel_x  out  8  current signed X velocity.
- vel_y  out  8  current signed Y velocity.
- hit_x  out  1  one-cycle pulse on an X-wall reflection.
- hit_y  out  1  one-cycle pulse on a Y-wall reflection.
- bounce_count  out  16  saturating count of reflections.
- busy  out  1  high while the FSM is not in IDLE.

## Operation
- **Reset values:**
  - offset_x=INIT_X, offset_y=INIT_Y
  - vel_x=INIT_VX, vel_y=INIT_VY
  - hit_x=hit_y=0, bounce_count=0, busy=0
  - FSM=IDLE; sync flops s1..s3=0; pending-velocity flag=0
- **Synchronizer:** frame_int passes through 2 flops (s1, s2). s3 delays s2 by one cycle. fire = s2 & ~s3, i.e. the rising edge only.
- **Limits:** MAX_X = SCREEN_W-SPRITE_W (736); MAX_Y = SCREEN_H-SPRITE_H (416).
- **FSM states:**
  - IDLE: on fire with pause=0, go to CALC. On fire with pause=1, stay in IDLE with no state change. No fire: stay.
  - CALC: sx = offset_x + sext(vel_x) and sy = offset_y + sext(vel_y), both 17-bit signed. Go to CHECK.
  - CHECK: per axis, with MAX = MAX_X or MAX_Y:
    - sum < 0: pos = -sum; vel = +|vel|; hit set.
    - sum > MAX: pos = 2*MAX - sum; vel = -|vel|; hit set.
    - otherwise: pos = sum.
    - After reflection, clamp pos to [0, MAX].
    - Write results into working registers, then go to COMMIT.
  - COMMIT: load offset_x/offset_y from the working registers in the same cycle. Pulse hit_x/hit_y. Add (hit_x+hit_y) to bounce_count, saturating at 0xFFFF. Go to IDLE.
- **|vel| = -128 case:** |vel| for -128 saturates to +127.
- **vel = 0:** the axis does not move. No hit is possible unless the start position is out of range.
- **vel_we in IDLE:** vel_x/vel_y load on the next edge.
- **vel_we while busy:** the values are captured into a pending register. COMMIT uses the pending values instead of the reflected velocities. The position for the current frame uses the old velocity.
- **fire while busy:** ignored.
- **Asynchronous reset mid-operation:** aborts the update and restores all reset values. Outputs never show a partial update.

## Timing
- Edge 1 is the first clk edge that samples frame_int high.
  - Edge 2: fire is high.
  - Edge 3: IDLE→CALC; busy goes high.
  - Edge 4: CALC→CHECK.
  - Edge 5: CHECK→COMMIT.
  - Edge 6: offsets, velocities, hit pulses and bounce_count update; FSM returns to IDLE; busy goes low.
- Latency: 6 clk edges from frame_int sampled high to new offsets.
- hit_x/hit_y are high for exactly the cycle after edge 6.
- frame_int must stay high for at least 2 clk cycles and low for at least 2 clk cycles between frames.
- One update per frame_int rising edge, even if frame_int stays high.

## Test plan
- **Reset:** assert reset low → offset=(123,234), vel=(1,1), bounce_count=0, busy=0. Hold frame_int high through reset release → no update until a new rising edge.
- **Plain step:** one frame_int pulse → (124,235) on edge 6; busy high for exactly 3 cycles; no hit pulses.
- **Right-wall reflect:** x=730, vx=+10 → x=732, vx=-10, hit_x single pulse, bounce_count=1.
- **Corner:** (x,y)=(2,414), v=(-5,+4) → (3,414), v=(+5,-4), hit_x and hit_y in the same cycle, bounce_count+=2.
- **Pause and vel_we while busy:**
  - pause=1 at fire → outputs unchanged.
  - vel_we=(3,-2) at edge 4 → that frame moves by the old velocity; vel=(3,-2) after edge 6.
- **Reset mid-update:** reset asserted in CHECK → offsets=(123,234) immediately, busy=0. The next frame steps normally to (124,235).
